// File: rtl/vault_pkg.sv
// -----------------------------------------------------------------------------
// vault_pkg
// Shared types and constants for the vault input sequencer.
//   - seq_state_e : sequencer FSM states (ST_FAIL exists only when the
//                   VAULT_SEQ_TIMEOUT_EN macro is defined)
//   - PH_*        : phase indices driven on the phase output
//   - *_DONE      : "phase done" (all-ones) values per drive bus
// -----------------------------------------------------------------------------
package vault_pkg;

`ifdef VAULT_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE_CODE,
        ST_DRIVE_DONE,
        ST_WAIT_ALL,
        ST_FINISH,
        ST_FAIL
    } seq_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE_CODE,
        ST_DRIVE_DONE,
        ST_WAIT_ALL,
        ST_FINISH
    } seq_state_e;
`endif

    localparam logic [2:0] PH_KEYPAD  = 3'd0;
    localparam logic [2:0] PH_DIR     = 3'd1;
    localparam logic [2:0] PH_COLOR   = 3'd2;
    localparam logic [2:0] PH_PATTERN = 3'd3;
    localparam logic [2:0] PH_FINAL   = 3'd4;
    localparam logic [2:0] PH_WAIT    = 3'd5;

    localparam logic [3:0] KEYPAD_DONE  = 4'hF;
    localparam logic [2:0] DIR_DONE     = 3'h7;
    localparam logic [3:0] COLOR_DONE   = 4'hF;
    localparam logic [7:0] PATTERN_DONE = 8'hFF;
    localparam logic [3:0] KEY_DONE     = 4'hF;

endpackage

// File: rtl/vault_input_sequencer_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Loadable down-counter with an expiry flag. Loading N-1 makes expired rise
// on the N-th enabled cycle after the load, so the caller can reload on the
// same edge it acts on expiry.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset (count -> 0)
//   load     : load load_val on this edge (wins over counting)
//   load_val : value to load
//   en       : count down while high
//   expired  : en high and count at zero
// -----------------------------------------------------------------------------
module hold_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == '0);

endmodule

// File: rtl/vault_input_sequencer.sv
// -----------------------------------------------------------------------------
// vault_input_sequencer
// Drives the vault puzzle input buses phase by phase (keypad, direction,
// color, pattern, code+final key). Each phase shows its code value for
// HOLD_CYCLES cycles, then the all-ones "done" value for HOLD_CYCLES cycles.
// After phase 4 it waits for all_done and latches vault_escape.
// Optional feature macro: VAULT_SEQ_TIMEOUT_EN adds a TIMEOUT_CYCLES bound on
// the all_done wait and a sticky timeout_err flag; without it timeout_err = 0.
// Ports:
//   clk, rst            : clock; synchronous active-low reset
//   start               : begin a sequence (only looked at in IDLE)
//   abort               : back to IDLE, all buses zeroed (beats start/all_done)
//   all_done            : vault finished
//   vault_escape        : vault result, captured with all_done
//   keypad_input .. final_key_input : drive buses to the vault
//   phase               : 0..4 while driving, 5 while waiting/finished
//   busy                : sequence in progress
//   seq_done            : one-cycle completion pulse
//   escaped             : captured vault_escape
//   timeout_err         : sticky all_done timeout flag
// -----------------------------------------------------------------------------
module vault_input_sequencer
    import vault_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter logic [3:0]  KEYPAD_CODE  = 4'h3,
    parameter logic [2:0]  DIR_CODE     = 3'b010,
    parameter logic [3:0]  COLOR_CODE   = 4'h2,
    parameter logic [7:0]  PATTERN_CODE = 8'h55,
    parameter logic [3:0]  CODE_VAL     = 4'hA,
    parameter logic [3:0]  FINAL_KEY    = 4'h5
`ifdef VAULT_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       all_done,
    input  logic       vault_escape,
    output logic [3:0] keypad_input,
    output logic [2:0] direction_input,
    output logic [3:0] color_input,
    output logic [7:0] pattern_input,
    output logic [3:0] code_input,
    output logic [3:0] final_key_input,
    output logic [2:0] phase,
    output logic       busy,
    output logic       seq_done,
    output logic       escaped,
    output logic       timeout_err
);

    // Down-counter is loaded with N-1 so it expires on the N-th cycle.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    seq_state_e state_q, state_d;
    logic [3:0] keypad_q, keypad_d;
    logic [2:0] dir_q, dir_d;
    logic [3:0] color_q, color_d;
    logic [7:0] pattern_q, pattern_d;
    logic [3:0] code_q, code_d;
    logic [3:0] final_key_q, final_key_d;
    logic [2:0] phase_q, phase_d;
    logic       busy_q, busy_d;
    logic       seq_done_q, seq_done_d;
    logic       escaped_q, escaped_d;

    logic hold_load;
    logic hold_en;
    logic hold_expired;

    assign hold_en = (state_q == ST_DRIVE_CODE) || (state_q == ST_DRIVE_DONE);

    hold_timer #(.WIDTH(8)) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .en       (hold_en),
        .expired  (hold_expired)
    );

`ifdef VAULT_SEQ_TIMEOUT_EN
    localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic timeout_err_q, timeout_err_d;
    logic wait_load;
    logic wait_expired;

    hold_timer #(.WIDTH(16)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .en       (state_q == ST_WAIT_ALL),
        .expired  (wait_expired)
    );
`endif

    always_comb begin
        state_d     = state_q;
        keypad_d    = keypad_q;
        dir_d       = dir_q;
        color_d     = color_q;
        pattern_d   = pattern_q;
        code_d      = code_q;
        final_key_d = final_key_q;
        phase_d     = phase_q;
        busy_d      = busy_q;
        seq_done_d  = 1'b0;
        escaped_d   = escaped_q;
        hold_load   = 1'b0;
`ifdef VAULT_SEQ_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
        wait_load     = 1'b0;
`endif

        if (abort) begin
            state_d     = ST_IDLE;
            keypad_d    = '0;
            dir_d       = '0;
            color_d     = '0;
            pattern_d   = '0;
            code_d      = '0;
            final_key_d = '0;
            phase_d     = PH_KEYPAD;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // A new run starts from a clean slate: later buses
                        // stay 0 until their own phase begins.
                        state_d     = ST_DRIVE_CODE;
                        keypad_d    = KEYPAD_CODE;
                        dir_d       = '0;
                        color_d     = '0;
                        pattern_d   = '0;
                        code_d      = '0;
                        final_key_d = '0;
                        phase_d     = PH_KEYPAD;
                        busy_d      = 1'b1;
                        escaped_d   = 1'b0;
                        hold_load   = 1'b1;
`ifdef VAULT_SEQ_TIMEOUT_EN
                        timeout_err_d = 1'b0;
`endif
                    end
                end

                ST_DRIVE_CODE: begin
                    if (hold_expired) begin
                        state_d   = ST_DRIVE_DONE;
                        hold_load = 1'b1;
                        case (phase_q)
                            PH_KEYPAD:  keypad_d  = KEYPAD_DONE;
                            PH_DIR:     dir_d     = DIR_DONE;
                            PH_COLOR:   color_d   = COLOR_DONE;
                            PH_PATTERN: pattern_d = PATTERN_DONE;
                            PH_FINAL: begin
                                code_d      = KEY_DONE;
                                final_key_d = KEY_DONE;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_DRIVE_DONE: begin
                    if (hold_expired) begin
                        if (phase_q == PH_FINAL) begin
                            state_d = ST_WAIT_ALL;
                            phase_d = PH_WAIT;
`ifdef VAULT_SEQ_TIMEOUT_EN
                            wait_load = 1'b1;
`endif
                        end else begin
                            state_d   = ST_DRIVE_CODE;
                            phase_d   = phase_q + 3'd1;
                            hold_load = 1'b1;
                            // Load the code of the phase being entered.
                            case (phase_q)
                                PH_KEYPAD:  dir_d     = DIR_CODE;
                                PH_DIR:     color_d   = COLOR_CODE;
                                PH_COLOR:   pattern_d = PATTERN_CODE;
                                PH_PATTERN: begin
                                    code_d      = CODE_VAL;
                                    final_key_d = FINAL_KEY;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                ST_WAIT_ALL: begin
                    if (all_done) begin
                        state_d    = ST_FINISH;
                        escaped_d  = vault_escape;
                        seq_done_d = 1'b1;
                        busy_d     = 1'b0;
                    end
`ifdef VAULT_SEQ_TIMEOUT_EN
                    else if (wait_expired) begin
                        state_d       = ST_FAIL;
                        timeout_err_d = 1'b1;
                        busy_d        = 1'b0;
                    end
`endif
                end

                // FINISH / FAIL last one cycle; drive buses are left as is.
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            keypad_q    <= '0;
            dir_q       <= '0;
            color_q     <= '0;
            pattern_q   <= '0;
            code_q      <= '0;
            final_key_q <= '0;
            phase_q     <= PH_KEYPAD;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            escaped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            keypad_q    <= keypad_d;
            dir_q       <= dir_d;
            color_q     <= color_d;
            pattern_q   <= pattern_d;
            code_q      <= code_d;
            final_key_q <= final_key_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
            escaped_q   <= escaped_d;
        end
    end

`ifdef VAULT_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign keypad_input    = keypad_q;
    assign direction_input = dir_q;
    assign color_input     = color_q;
    assign pattern_input   = pattern_q;
    assign code_input      = code_q;
    assign final_key_input = final_key_q;
    assign phase           = phase_q;
    assign busy            = busy_q;
    assign seq_done        = seq_done_q;
    assign escaped         = escaped_q;

endmodule

// File: tb/tb_vault_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vault_input_sequencer
// Two sequencers: dut0 with default HOLD_CYCLES=2, dut1 with HOLD_CYCLES=1.
// Expected bus values come from a timeline model: with hold h, the value
// shown k cycles after the start edge is segment k/h of ten segments
// (code, done) x five phases.
// -----------------------------------------------------------------------------
module tb_vault_input_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // dut0 signals
    logic       start0, abort0, ad0, ve0;
    logic [3:0] kp0, col0, code0, fk0;
    logic [2:0] dir0, ph0;
    logic [7:0] pat0;
    logic       busy0, sd0, esc_o0, to0;

    // dut1 signals
    logic       start1, abort1, ad1, ve1;
    logic [3:0] kp1, col1, code1, fk1;
    logic [2:0] dir1, ph1;
    logic [7:0] pat1;
    logic       busy1, sd1, esc_o1, to1;

    vault_input_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .all_done(ad0), .vault_escape(ve0),
        .keypad_input(kp0), .direction_input(dir0), .color_input(col0),
        .pattern_input(pat0), .code_input(code0), .final_key_input(fk0),
        .phase(ph0), .busy(busy0), .seq_done(sd0), .escaped(esc_o0),
        .timeout_err(to0)
    );

    vault_input_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .all_done(ad1), .vault_escape(ve1),
        .keypad_input(kp1), .direction_input(dir1), .color_input(col1),
        .pattern_input(pat1), .code_input(code1), .final_key_input(fk1),
        .phase(ph1), .busy(busy1), .seq_done(sd1), .escaped(esc_o1),
        .timeout_err(to1)
    );

    logic [7:0] bus0 [6];
    logic [7:0] bus1 [6];
    assign bus0[0] = {4'h0, kp0};
    assign bus0[1] = {5'h0, dir0};
    assign bus0[2] = {4'h0, col0};
    assign bus0[3] = pat0;
    assign bus0[4] = {4'h0, code0};
    assign bus0[5] = {4'h0, fk0};
    assign bus1[0] = {4'h0, kp1};
    assign bus1[1] = {5'h0, dir1};
    assign bus1[2] = {4'h0, col1};
    assign bus1[3] = pat1;
    assign bus1[4] = {4'h0, code1};
    assign bus1[5] = {4'h0, fk1};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] code_val(input int b);
        case (b)
            0: return 8'h03;
            1: return 8'h02;
            2: return 8'h02;
            3: return 8'h55;
            4: return 8'h0A;
            default: return 8'h05;
        endcase
    endfunction

    function automatic logic [7:0] done_val(input int b);
        case (b)
            1: return 8'h07;
            3: return 8'hFF;
            default: return 8'h0F;
        endcase
    endfunction

    // Bus b (0..5; code and final key both belong to phase 4), k cycles
    // after the start edge, hold h.
    function automatic logic [7:0] exp_bus(input int b, input int k, input int h);
        int seg;
        int p;
        int bp;
        seg = k / h;
        if (seg >= 10) return done_val(b);
        p  = seg / 2;
        bp = (b > 4) ? 4 : b;
        if (bp < p) return done_val(b);
        if (bp > p) return 8'h00;
        return (seg % 2 == 1) ? done_val(b) : code_val(b);
    endfunction

    function automatic logic [2:0] exp_phase(input int k, input int h);
        int seg;
        seg = k / h;
        return (seg >= 10) ? 3'd5 : 3'(seg / 2);
    endfunction

    task automatic check_drive(input bit d1, input int k);
        int h;
        string nm;
        h  = d1 ? 1 : 2;
        nm = d1 ? "dut1" : "dut0";
        for (int b = 0; b < 6; b++) begin
            check($sformatf("%s k%0d bus%0d", nm, k, b), d1 ? bus1[b] : bus0[b], exp_bus(b, k, h));
        end
        check($sformatf("%s k%0d phase", nm, k), d1 ? ph1 : ph0, exp_phase(k, h));
        check($sformatf("%s k%0d busy", nm, k), d1 ? busy1 : busy0, 1'b1);
        check($sformatf("%s k%0d seq_done", nm, k), d1 ? sd1 : sd0, 1'b0);
    endtask

    task automatic check_idle_zero(input bit d1, input string tag);
        for (int b = 0; b < 6; b++) begin
            check($sformatf("%s bus%0d", tag, b), d1 ? bus1[b] : bus0[b], 8'h00);
        end
        check({tag, " phase"}, d1 ? ph1 : ph0, 3'd0);
        check({tag, " busy"}, d1 ? busy1 : busy0, 1'b0);
        check({tag, " seq_done"}, d1 ? sd1 : sd0, 1'b0);
    endtask

    task automatic check_reset(input bit d1, input string tag);
        check_idle_zero(d1, tag);
        check({tag, " escaped"}, d1 ? esc_o1 : esc_o0, 1'b0);
        check({tag, " timeout_err"}, d1 ? to1 : to0, 1'b0);
    endtask

    initial begin
        int lat;
        int kab;
        int kr;
        logic esc;
        logic esc1;
        bit saw_done;

        rst = 1'b0;
        {start0, abort0, ad0, ve0} = '0;
        {start1, abort1, ad1, ve1} = '0;
        repeat (2) step();
        check_reset(1'b0, "reset dut0");
        check_reset(1'b1, "reset dut1");
        rst = 1'b1;
        step();

        // ---- full default sequence, stray start at cycle 5 ----
        start0 = 1'b1;
        step();
        for (int k = 0; k <= 20; k++) begin
            check_drive(1'b0, k);
            start0 = (k == 4);
            if (k < 20) step();
        end
        lat = $urandom_range(0, 5);
        repeat (lat) begin
            step();
            check("wait phase", ph0, 3'd5);
            check("wait busy", busy0, 1'b1);
        end
        esc = 1'($urandom_range(0, 1));
        ad0 = 1'b1;
        ve0 = esc;
        step();
        check("finish seq_done", sd0, 1'b1);
        check("finish busy", busy0, 1'b0);
        check("finish escaped", esc_o0, esc);
        ad0 = 1'b0;
        ve0 = ~esc;
        step();
        check("post seq_done", sd0, 1'b0);
        check("post busy", busy0, 1'b0);
        check("post escaped", esc_o0, esc);
        check("post keypad persists", kp0, 4'hF);
        check("post pattern persists", pat0, 8'hFF);

        // ---- abort during phase 2 code, then clean restart ----
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        check("start clears escaped", esc_o0, 1'b0);
        kab = $urandom_range(8, 9);
        for (int k = 0; k <= kab; k++) begin
            check_drive(1'b0, k);
            if (k < kab) step();
        end
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check_idle_zero(1'b0, "abort");
        step();
        check("abort no seq_done", sd0, 1'b0);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        kr = $urandom_range(12, 15);
        for (int k = 0; k <= kr; k++) begin
            check_drive(1'b0, k);
            if (k < kr) step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_reset(1'b0, "mid rst");

        // ---- HOLD_CYCLES=1, all_done high on WAIT_ALL entry, start held ----
        esc1   = 1'($urandom_range(0, 1));
        start1 = 1'b1;
        step();
        for (int k = 0; k <= 10; k++) begin
            check_drive(1'b1, k);
            if (k == 9) begin
                ad1 = 1'b1;
                ve1 = esc1;
            end
            if (k < 10) step();
        end
        step();
        check("h1 seq_done", sd1, 1'b1);
        check("h1 busy", busy1, 1'b0);
        check("h1 escaped", esc_o1, esc1);
        ad1 = 1'b0;
        step();
        check("h1 idle busy", busy1, 1'b0);
        check("h1 idle seq_done", sd1, 1'b0);
        step();
        check("h1 retrigger busy", busy1, 1'b1);
        check("h1 retrigger phase", ph1, 3'd0);
        check("h1 retrigger keypad", kp1, 4'h3);
        start1 = 1'b0;
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        check_idle_zero(1'b1, "h1 abort");

        // ---- all_done never arrives ----
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (20) step();
        check_drive(1'b0, 20);
`ifdef VAULT_SEQ_TIMEOUT_EN
        repeat (15) step();
        check("to pre busy", busy0, 1'b1);
        check("to pre err", to0, 1'b0);
        step();
        check("to err", to0, 1'b1);
        check("to busy", busy0, 1'b0);
        check("to seq_done", sd0, 1'b0);
        step();
        check("to sticky", to0, 1'b1);
        check("to idle seq_done", sd0, 1'b0);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        check("to cleared on start", to0, 1'b0);
        check("to restart busy", busy0, 1'b1);
`else
        saw_done = 1'b0;
        repeat (30) begin
            step();
            if (sd0 !== 1'b0) saw_done = 1'b1;
        end
        check("nowait seq_done seen", saw_done, 1'b0);
        check("nowait busy", busy0, 1'b1);
        check("nowait phase", ph0, 3'd5);
        check("nowait timeout_err", to0, 1'b0);
`endif
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check("final abort busy", busy0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
